// File: rtl/goertzel_bank.sv
// Multi-bin Goertzel engine: NF parallel second-order recurrences over one sample stream,
// emitting saturated per-bin power |X(k)|^2 once per N-sample frame under a start/stop FSM.
module goertzel_bank #(
    parameter int NF  = 2,
    parameter int SW  = 8,
    parameter int DW  = 32,
    parameter int CW  = 18,
    parameter int NSW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NF*CW-1:0]     cfg_coef_i,
    input  logic [NSW-1:0]       cfg_num_samp_i,
    input  logic                 cfg_cont_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic signed [SW-1:0] s_data_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [NF*2*DW-1:0]   m_power_o,
    output logic [NSW-1:0]       m_frame_o,
    output logic                 busy_o,
    output logic                 cfg_err_o,
    output logic                 ovf_o
);

    localparam int FB   = CW - 3;
    localparam int PW   = CW + DW;
    localparam int SUMW = PW + 2;
    localparam int PAW  = 2 * DW + 1;
    localparam int PBW  = CW + 2 * DW;
    localparam int DIFW = PBW + 2;
    localparam int PWR  = 2 * DW;

    localparam logic signed [SUMW-1:0] S_MAX = {{(SUMW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SUMW-1:0] S_MIN = {{(SUMW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DIFW-1:0] P_MAX = {{(DIFW-PWR+1){1'b0}}, {(PWR-1){1'b1}}};
    localparam logic signed [DIFW-1:0] P_MIN = {{(DIFW-PWR+1){1'b1}}, {(PWR-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ACC, PRE, FIN1, FIN2, OUT} state_t;

    state_t               state;
    logic [NSW-1:0]       count;
    logic [NSW-1:0]       n_samp;
    logic                 cont;
    logic signed [CW-1:0] coef  [NF];
    logic signed [DW-1:0] s1    [NF];
    logic signed [DW-1:0] s2    [NF];
    logic signed [PW-1:0] t_p0  [NF];
    logic signed [PAW-1:0] pa_p1 [NF];
    logic signed [PBW-1:0] pb_p1 [NF];

    logic signed [PW-1:0]   tcoef [NF];
    logic signed [SUMW-1:0] sum   [NF];
    logic signed [DW-1:0]   s0    [NF];
    logic signed [DIFW-1:0] diff  [NF];
    logic [NF-1:0]          s0_clip;
    logic [NF-1:0]          pwr_clip;

    function automatic logic signed [DW-1:0] sat_state(input logic signed [SUMW-1:0] v);
        if (v > S_MAX)      return S_MAX[DW-1:0];
        else if (v < S_MIN) return S_MIN[DW-1:0];
        else                return v[DW-1:0];
    endfunction

    function automatic logic clip_state(input logic signed [SUMW-1:0] v);
        return (v > S_MAX) || (v < S_MIN);
    endfunction

    function automatic logic signed [PWR-1:0] sat_pwr(input logic signed [DIFW-1:0] v);
        if (v > P_MAX)      return P_MAX[PWR-1:0];
        else if (v < P_MIN) return P_MIN[PWR-1:0];
        else                return v[PWR-1:0];
    endfunction

    function automatic logic clip_pwr(input logic signed [DIFW-1:0] v);
        return (v > P_MAX) || (v < P_MIN);
    endfunction

    // Recurrence datapath; tcoef also feeds the PRE stage so one multiplier serves both.
    always_comb begin
        s0_clip  = '0;
        pwr_clip = '0;
        for (int k = 0; k < NF; k++) begin
            tcoef[k]    = (PW'(coef[k]) * PW'(s1[k])) >>> FB;
            sum[k]      = SUMW'(s_data_i) + SUMW'(tcoef[k]) - SUMW'(s2[k]);
            s0[k]       = sat_state(sum[k]);
            s0_clip[k]  = clip_state(sum[k]);
            diff[k]     = DIFW'(pa_p1[k]) - DIFW'(pb_p1[k]);
            pwr_clip[k] = clip_pwr(diff[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s_ready_o <= 1'b0;
            m_valid_o <= 1'b0;
            busy_o    <= 1'b0;
            cfg_err_o <= 1'b0;
            ovf_o     <= 1'b0;
            m_power_o <= '0;
            m_frame_o <= '0;
            count     <= '0;
            n_samp    <= '0;
            cont      <= 1'b0;
            for (int k = 0; k < NF; k++) begin
                coef[k]  <= '0;
                s1[k]    <= '0;
                s2[k]    <= '0;
                t_p0[k]  <= '0;
                pa_p1[k] <= '0;
                pb_p1[k] <= '0;
            end
        end else begin
            cfg_err_o <= 1'b0;
            if (stop_i && state != IDLE) begin
                state     <= IDLE;
                s_ready_o <= 1'b0;
                m_valid_o <= 1'b0;
                busy_o    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i && !stop_i) begin
                            if (cfg_num_samp_i == '0) begin
                                cfg_err_o <= 1'b1;
                            end else begin
                                state     <= ACC;
                                s_ready_o <= 1'b1;
                                busy_o    <= 1'b1;
                                ovf_o     <= 1'b0;
                                m_frame_o <= '0;
                                count     <= '0;
                                n_samp    <= cfg_num_samp_i;
                                cont      <= cfg_cont_i;
                                for (int k = 0; k < NF; k++) begin
                                    coef[k] <= cfg_coef_i[k*CW +: CW];
                                    s1[k]   <= '0;
                                    s2[k]   <= '0;
                                end
                            end
                        end
                    end
                    ACC: begin
                        if (s_valid_i && s_ready_o) begin
                            for (int k = 0; k < NF; k++) begin
                                s2[k] <= s1[k];
                                s1[k] <= s0[k];
                            end
                            if (|s0_clip) ovf_o <= 1'b1;
                            count <= count + 1'b1;
                            if (count == n_samp - 1'b1) begin
                                state     <= PRE;
                                s_ready_o <= 1'b0;
                            end
                        end
                    end
                    // Stage p0: scaled coef*s1, split from the power products for timing.
                    PRE: begin
                        for (int k = 0; k < NF; k++) t_p0[k] <= tcoef[k];
                        state <= FIN1;
                    end
                    // Stage p1: full-width power products.
                    FIN1: begin
                        for (int k = 0; k < NF; k++) begin
                            pa_p1[k] <= PAW'(s1[k]) * PAW'(s1[k]) + PAW'(s2[k]) * PAW'(s2[k]);
                            pb_p1[k] <= PBW'(t_p0[k]) * PBW'(s2[k]);
                        end
                        state <= FIN2;
                    end
                    // Stage p2: saturate into the result register.
                    FIN2: begin
                        for (int k = 0; k < NF; k++) m_power_o[k*PWR +: PWR] <= sat_pwr(diff[k]);
                        if (|pwr_clip) ovf_o <= 1'b1;
                        m_valid_o <= 1'b1;
                        state     <= OUT;
                    end
                    OUT: begin
                        if (m_ready_i) begin
                            m_valid_o <= 1'b0;
                            if (cont) begin
                                state     <= ACC;
                                s_ready_o <= 1'b1;
                                count     <= '0;
                                m_frame_o <= m_frame_o + 1'b1;
                                for (int k = 0; k < NF; k++) begin
                                    s1[k] <= '0;
                                    s2[k] <= '0;
                                end
                            end else begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        s_ready_o <= 1'b0;
                        m_valid_o <= 1'b0;
                        busy_o    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_goertzel_bank.sv
// Directed bench for goertzel_bank: table of single frames with hand-computed powers,
// plus sequences for latency, back-pressure, abort, config error, saturation and reset.
module tb_goertzel_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic [35:0]  cfg_coef;
    logic [15:0]  cfg_num_samp;
    logic         cfg_cont;
    logic         start;
    logic         stop;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_power;
    logic [15:0]  m_frame;
    logic         busy;
    logic         cfg_err;
    logic         ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    goertzel_bank dut (
        .clk(clk), .rst(rst),
        .cfg_coef_i(cfg_coef), .cfg_num_samp_i(cfg_num_samp), .cfg_cont_i(cfg_cont),
        .start_i(start), .stop_i(stop),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_power_o(m_power), .m_frame_o(m_frame),
        .busy_o(busy), .cfg_err_o(cfg_err), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          c0;
        int          c1;
        int          n;
        logic [31:0] x;   // sample i in bits [8i+7:8i]
        longint      p0;
        longint      p1;
    } vec_t;

    vec_t tbl [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input int c0, input int c1, input int n, input logic cont);
        cfg_coef     = {c1[17:0], c0[17:0]};
        cfg_num_samp = n[15:0];
        cfg_cont     = cont;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic feed(input logic [7:0] x);
        logic acc;
        int   guard;
        acc     = 1'b0;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = x;
        while (!acc && guard < 50) begin
            acc = s_ready;
            tick();
            guard++;
        end
        s_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL feed_timeout: got ready=0, expected ready=1");
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!m_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [127:0] held;
        logic        stable;

        tbl[0] = '{c0: 65536,  c1: 0,      n: 4, x: 32'h01010101, p0: 16, p1: 0};
        tbl[1] = '{c0: 0,      c1: 65536,  n: 4, x: 32'h00FF0001, p0: 4,  p1: 0};
        tbl[2] = '{c0: -65536, c1: 65536,  n: 4, x: 32'hFF01FF01, p0: 16, p1: 0};
        tbl[3] = '{c0: 32768,  c1: -32768, n: 3, x: 32'h0005FD02, p0: 7,  p1: 49};
        tbl[4] = '{c0: 49152,  c1: -49152, n: 2, x: 32'h0000FF03, p0: 6,  p1: 18};

        rst = 1'b1; cfg_coef = '0; cfg_num_samp = '0; cfg_cont = 1'b0;
        start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        tick();
        tick();
        check("reset_ctrl", 64'({s_ready, m_valid, busy, cfg_err, ovf}), 64'd0);
        check("reset_power0", m_power[63:0], 64'd0);
        check("reset_power1", m_power[127:64], 64'd0);
        check("reset_frame", 64'(m_frame), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            do_start(tbl[i].c0, tbl[i].c1, tbl[i].n, 1'b0);
            check($sformatf("v%0d_busy", i), 64'({busy, s_ready}), 64'd3);
            for (int j = 0; j < tbl[i].n; j++) feed(tbl[i].x[j*8 +: 8]);
            wait_result(lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
            check($sformatf("v%0d_power0", i), m_power[63:0], tbl[i].p0);
            check($sformatf("v%0d_power1", i), m_power[127:64], tbl[i].p1);
            check($sformatf("v%0d_frame_ovf", i), 64'({m_frame, ovf}), 64'd0);
            accept();
            check($sformatf("v%0d_done", i), 64'({m_valid, busy}), 64'd0);
        end

        // Continuous mode with result back-pressure.
        do_start(65536, 0, 4, 1'b1);
        for (int j = 0; j < 4; j++) feed(8'd1);
        wait_result(lat);
        held   = m_power;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (s_ready || !m_valid || m_power !== held) stable = 1'b0;
        end
        check("bp_hold", 64'(stable), 64'd1);
        accept();
        check("bp_next_frame", 64'({m_valid, s_ready, m_frame}), 64'({1'b0, 1'b1, 16'd1}));
        for (int j = 0; j < 4; j++) feed(8'd1);
        wait_result(lat);
        check("bp_power0", m_power[63:0], 64'd16);
        check("bp_frame", 64'(m_frame), 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("bp_stop", 64'({busy, m_valid, s_ready}), 64'd0);

        // Abort mid-frame; a start while busy must be ignored.
        do_start(65536, 0, 8, 1'b0);
        feed(8'd1);
        feed(8'd1);
        do_start(65536, 0, 0, 1'b0);
        check("busy_start_ignored", 64'({busy, cfg_err}), 64'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("abort_idle", 64'({busy, s_ready}), 64'd0);
        stable = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (m_valid) stable = 1'b0;
        end
        check("abort_no_result", 64'(stable), 64'd1);
        do_start(65536, 0, 4, 1'b0);
        for (int j = 0; j < 4; j++) feed(8'd1);
        wait_result(lat);
        check("restart_power0", m_power[63:0], 64'd16);
        accept();

        // Stop and start together in IDLE: stop wins.
        stop = 1'b1;
        do_start(65536, 0, 4, 1'b0);
        stop = 1'b0;
        check("stop_beats_start", 64'({busy, s_ready}), 64'd0);

        // N == 0 is rejected with a one-cycle error pulse.
        do_start(65536, 0, 0, 1'b0);
        check("cfg_err_pulse", 64'({cfg_err, busy}), 64'd2);
        tick();
        check("cfg_err_clear", 64'({cfg_err, busy}), 64'd0);

        // Unstable coefficient drives bin 0 into state saturation; bin 1 is a plain DC bin.
        do_start(131071, 65536, 24, 1'b0);
        for (int j = 0; j < 24; j++) feed(8'd127);
        wait_result(lat);
        check("sat_ovf", 64'(ovf), 64'd1);
        check("sat_power0", m_power[63:0], 64'h8000_8001_FFFE_FFFE);
        check("sat_power1", m_power[127:64], 64'd9290304);
        accept();
        check("ovf_sticky", 64'({ovf, busy}), 64'd2);
        do_start(65536, 0, 4, 1'b0);
        check("ovf_cleared_on_start", 64'(ovf), 64'd0);

        // Reset in the middle of a frame discards state and result.
        feed(8'd1);
        feed(8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midframe_reset_ctrl", 64'({busy, s_ready, m_valid}), 64'd0);
        check("midframe_reset_power", m_power[63:0], 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
